text_tx_serializer: RTL

- Transmit-side counterpart of the text receive path.
- Takes a packed text buffer (up to MAX_TEXT_BYTES bytes plus a size) and, on a send request, streams the bytes one at a time to the UART byte transmitter over a valid/ready handshake.
- Sits between application logic (e.g. the echo block's tx_text_bytes/tx_text_size outputs) and the byte-level UART TX.

---
 rtl/text_io_pkg.sv | 25 ++
 rtl/rise_edge_detect.sv | 26 ++
 rtl/text_tx_serializer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/text_io_pkg.sv
// Shared text I/O definitions for the text receive, echo and transmit blocks.
// Contents: default buffer geometry, transmit state encoding, ASCII control
// characters used for line termination.
// Optional feature macro: TEXT_TX_CRLF_EN adds the CR and LF transmit states.
package text_io_pkg;

  localparam int DEF_MAX_TEXT_BYTES = 32;
  localparam int DEF_SIZE_WIDTH     = 8;
  localparam int DEF_BYTE_WIDTH     = 8;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_SEND,
    TX_DONE
`ifdef TEXT_TX_CRLF_EN
    ,
    TX_CR,
    TX_LF
`endif
  } tx_state_t;

endpackage

// File: rtl/rise_edge_detect.sv
// Rising-edge detector: pulse is high for the cycle in which sig is high
// and was low on the previous clock edge.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset (history clears to 0)
//   sig   - level input
//   pulse - one-cycle rising-edge strobe
module rise_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic pulse
);

  logic sig_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_prev <= 1'b0;
    else        sig_prev <= sig;
  end

  // History resets to 0, so a level held high through reset release
  // still yields exactly one pulse.
  assign pulse = sig & ~sig_prev;

endmodule

// File: rtl/text_tx_serializer.sv
// Text transmit serializer: latches a packed text buffer on a send request
// and streams its bytes, byte 0 first, to the UART byte transmitter over a
// valid/ready handshake.
// Optional feature macro: TEXT_TX_CRLF_EN appends CR (0x0D) and LF (0x0A)
// after the text, including for zero-length text.
// Ports:
//   clk           - system clock
//   rst_n         - asynchronous active-low reset
//   text_bytes    - packed text, byte 0 in bits [7:0]
//   text_size     - number of valid bytes (clamped to MAX_TEXT_BYTES)
//   text_send     - send request, rising edge starts a transfer
//   busy          - transfer in progress (through the done cycle)
//   text_done     - one-cycle completion pulse
//   tx_byte       - byte presented to UART TX
//   tx_byte_valid - tx_byte is valid
//   tx_byte_ready - UART TX accepts tx_byte this cycle
module text_tx_serializer
  import text_io_pkg::*;
#(
  parameter int MAX_TEXT_BYTES = DEF_MAX_TEXT_BYTES,
  parameter int SIZE_WIDTH     = DEF_SIZE_WIDTH,
  parameter int BYTE_WIDTH     = DEF_BYTE_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [MAX_TEXT_BYTES*BYTE_WIDTH-1:0] text_bytes,
  input  logic [SIZE_WIDTH-1:0]                text_size,
  input  logic                                 text_send,
  output logic                                 busy,
  output logic                                 text_done,
  output logic [BYTE_WIDTH-1:0]                tx_byte,
  output logic                                 tx_byte_valid,
  input  logic                                 tx_byte_ready
);

  // Extra bit so that len can hold MAX_TEXT_BYTES itself.
  localparam int IDX_W = $clog2(MAX_TEXT_BYTES) + 1;

  tx_state_t        state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [IDX_W-1:0] len_q, len_d;
  logic [IDX_W-1:0] len_clamped;
  logic             load;
  logic             send_edge;

  logic [BYTE_WIDTH-1:0] buf_q [MAX_TEXT_BYTES];

  rise_edge_detect u_send_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (text_send),
    .pulse (send_edge)
  );

  always_comb begin
    if (int'(text_size) > MAX_TEXT_BYTES) len_clamped = IDX_W'(MAX_TEXT_BYTES);
    else                                  len_clamped = IDX_W'(text_size);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      index_q <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      len_q   <= len_d;
    end
  end

  // Data storage needs no reset: it is only read after a load.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < MAX_TEXT_BYTES; i++)
        buf_q[i] <= text_bytes[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    len_d         = len_q;
    load          = 1'b0;
    busy          = 1'b1;
    text_done     = 1'b0;
    tx_byte_valid = 1'b0;
    tx_byte       = '0;

    case (state_q)
      TX_IDLE: begin
        busy = 1'b0;
        if (send_edge) begin
          load    = 1'b1;
          len_d   = len_clamped;
          index_d = '0;
          if (len_clamped != '0) state_d = TX_SEND;
`ifdef TEXT_TX_CRLF_EN
          else                   state_d = TX_CR;
`else
          else                   state_d = TX_DONE;
`endif
        end
      end

      TX_SEND: begin
        tx_byte_valid = 1'b1;
        tx_byte       = buf_q[index_q[IDX_W-2:0]];
        if (tx_byte_ready) begin
          index_d = index_q + IDX_W'(1);
          if (index_q == len_q - IDX_W'(1)) begin
`ifdef TEXT_TX_CRLF_EN
            state_d = TX_CR;
`else
            state_d = TX_DONE;
`endif
          end
        end
      end

`ifdef TEXT_TX_CRLF_EN
      TX_CR: begin
        tx_byte_valid = 1'b1;
        tx_byte       = BYTE_WIDTH'(ASCII_CR);
        if (tx_byte_ready) state_d = TX_LF;
      end

      TX_LF: begin
        tx_byte_valid = 1'b1;
        tx_byte       = BYTE_WIDTH'(ASCII_LF);
        if (tx_byte_ready) state_d = TX_DONE;
      end
`endif

      TX_DONE: begin
        text_done = 1'b1;
        state_d   = TX_IDLE;
      end

      default: state_d = TX_IDLE;
    endcase
  end

endmodule
